// File: rtl/bp_pkg.sv
// Shared types and helpers for the dynamic branch predictor.
// Holds the 2-bit counter encoding, saturating updates and allocation constants.
package bp_pkg;

   typedef enum logic [1:0] {
      SNT = 2'b00,
      WNT = 2'b01,
      WT  = 2'b10,
      ST  = 2'b11
   } counter_t;

   localparam counter_t RESET_CNT    = WNT;
   localparam counter_t ALLOC_JUMP   = ST;
   localparam counter_t ALLOC_BRANCH = WT;

   function automatic counter_t sat_inc(input counter_t c);
      if (c == ST) return ST;
      return counter_t'(c + 2'd1);
   endfunction

   function automatic counter_t sat_dec(input counter_t c);
      if (c == SNT) return SNT;
      return counter_t'(c - 2'd1);
   endfunction

   // The upper counter bit is the taken/not-taken decision.
   function automatic logic is_taken(input counter_t c);
      return c[1];
   endfunction

endpackage

// File: rtl/bp_perf_counters.sv
// Wrap-around counters for resolved branches and mispredicts.
// Both count modulo 2^CNT_W and clear only on reset.
module bp_perf_counters #(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             incBranch,
   input  logic             incMispredict,
   output logic [CNT_W-1:0] branchCount,
   output logic [CNT_W-1:0] mispredictCount
);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         branchCount     <= '0;
         mispredictCount <= '0;
      end else begin
         if (incBranch)     branchCount     <= branchCount + CNT_W'(1);
         if (incMispredict) mispredictCount <= mispredictCount + CNT_W'(1);
      end
   end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters: combinational fetch lookup,
// execute-stage resolve/redirect, and training on resolved branches and jumps.
module branch_predictor
   import bp_pkg::*;
#(
   parameter int WIDTH   = 32,
   parameter int ENTRIES = 64,
   parameter int CNT_W   = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic [WIDTH-1:0] pc_f,
   output logic             predict_taken_f,
   output logic [WIDTH-1:0] predict_target_f,
   input  logic             update_en_e,
   input  logic             is_jump_e,
   input  logic [WIDTH-1:0] pc_e,
   input  logic             taken_e,
   input  logic [WIDTH-1:0] target_e,
   input  logic             pred_taken_e,
   input  logic [WIDTH-1:0] pred_target_e,
   output logic             mispredict_e,
   output logic [WIDTH-1:0] redirect_pc_e,
   output logic [CNT_W-1:0] branch_count,
   output logic [CNT_W-1:0] mispredict_count
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = WIDTH - IDX_W - 2;

   logic             validQ  [ENTRIES];
   logic [TAG_W-1:0] tagQ    [ENTRIES];
   logic [WIDTH-1:0] targetQ [ENTRIES];
   counter_t         cntQ    [ENTRIES];

   logic [IDX_W-1:0] fIdx, eIdx;
   logic [TAG_W-1:0] fTag, eTag;
   logic             fHit, eHit;
   counter_t         fCnt;

   // Instructions are word aligned; the low PC bits never reach the table.
   logic [3:0] unusedPcBits;
   assign unusedPcBits = {pc_f[1:0], pc_e[1:0]};

   assign fIdx = pc_f[IDX_W+1:2];
   assign fTag = pc_f[WIDTH-1:IDX_W+2];
   assign eIdx = pc_e[IDX_W+1:2];
   assign eTag = pc_e[WIDTH-1:IDX_W+2];

   assign fHit = validQ[fIdx] && (tagQ[fIdx] == fTag);
   assign eHit = validQ[eIdx] && (tagQ[eIdx] == eTag);
   assign fCnt = cntQ[fIdx];

   always_comb begin
      predict_taken_f  = fHit && is_taken(fCnt);
      predict_target_f = predict_taken_f ? targetQ[fIdx] : pc_f + WIDTH'(4);
   end

   always_comb begin
      mispredict_e  = 1'b0;
      redirect_pc_e = '0;
      if (update_en_e) begin
         mispredict_e  = (taken_e != pred_taken_e) ||
                         (taken_e && pred_taken_e && (target_e != pred_target_e));
         redirect_pc_e = taken_e ? target_e : pc_e + WIDTH'(4);
      end
   end

   // clear wins over a same-cycle update; tags and targets are left stale.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < ENTRIES; i++) begin
            validQ[i]  <= 1'b0;
            tagQ[i]    <= '0;
            targetQ[i] <= '0;
            cntQ[i]    <= RESET_CNT;
         end
      end else if (clear) begin
         for (int i = 0; i < ENTRIES; i++) begin
            validQ[i] <= 1'b0;
            cntQ[i]   <= RESET_CNT;
         end
      end else if (update_en_e) begin
         if (eHit) begin
            cntQ[eIdx] <= taken_e ? sat_inc(cntQ[eIdx]) : sat_dec(cntQ[eIdx]);
            if (taken_e) targetQ[eIdx] <= target_e;
         end else if (taken_e) begin
            validQ[eIdx]  <= 1'b1;
            tagQ[eIdx]    <= eTag;
            targetQ[eIdx] <= target_e;
            cntQ[eIdx]    <= is_jump_e ? ALLOC_JUMP : ALLOC_BRANCH;
         end
      end
   end

   bp_perf_counters #(
      .CNT_W(CNT_W)
   ) perfCounters (
      .clk            (clk),
      .rst            (rst),
      .incBranch      (update_en_e),
      .incMispredict  (mispredict_e),
      .branchCount    (branch_count),
      .mispredictCount(mispredict_count)
   );

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a driver pushes model expectations per cycle,
// a monitor on the falling edge pops and compares them against the DUT outputs.
module tb_branch_predictor;

   localparam int WIDTH   = 32;
   localparam int ENTRIES = 8;
   localparam int CNT_W   = 4;
   localparam int IDX_W   = 3;

   logic             clk = 1'b0;
   logic             rst;
   logic             clear;
   logic [WIDTH-1:0] pc_f;
   logic             predict_taken_f;
   logic [WIDTH-1:0] predict_target_f;
   logic             update_en_e;
   logic             is_jump_e;
   logic [WIDTH-1:0] pc_e;
   logic             taken_e;
   logic [WIDTH-1:0] target_e;
   logic             pred_taken_e;
   logic [WIDTH-1:0] pred_target_e;
   logic             mispredict_e;
   logic [WIDTH-1:0] redirect_pc_e;
   logic [CNT_W-1:0] branch_count;
   logic [CNT_W-1:0] mispredict_count;

   branch_predictor #(
      .WIDTH  (WIDTH),
      .ENTRIES(ENTRIES),
      .CNT_W  (CNT_W)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .clear           (clear),
      .pc_f            (pc_f),
      .predict_taken_f (predict_taken_f),
      .predict_target_f(predict_target_f),
      .update_en_e     (update_en_e),
      .is_jump_e       (is_jump_e),
      .pc_e            (pc_e),
      .taken_e         (taken_e),
      .target_e        (target_e),
      .pred_taken_e    (pred_taken_e),
      .pred_target_e   (pred_target_e),
      .mispredict_e    (mispredict_e),
      .redirect_pc_e   (redirect_pc_e),
      .branch_count    (branch_count),
      .mispredict_count(mispredict_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic        pt;
      logic [31:0] ptg;
      logic        mp;
      logic [31:0] rd;
      logic [31:0] bc;
      logic [31:0] mc;
   } exp_t;

   exp_t expQ[$];
   int   checks = 0;
   int   fails  = 0;

   // Reference model: a plain table of (valid, tag, target, strength 0..3).
   bit          mValid  [ENTRIES];
   logic [31:0] mTag    [ENTRIES];
   logic [31:0] mTarget [ENTRIES];
   int          mCnt    [ENTRIES];
   int          mBc, mMc;

   function automatic int idxOf(input logic [31:0] pc);
      return int'((pc >> 2) % ENTRIES);
   endfunction

   function automatic logic [31:0] tagOf(input logic [31:0] pc);
      return pc >> (IDX_W + 2);
   endfunction

   function automatic bit modelHit(input logic [31:0] pc);
      return mValid[idxOf(pc)] && (mTag[idxOf(pc)] == tagOf(pc));
   endfunction

   function automatic bit modelTaken(input logic [31:0] pc);
      return modelHit(pc) && (mCnt[idxOf(pc)] >= 2);
   endfunction

   function automatic logic [31:0] modelTarget(input logic [31:0] pc);
      return modelTaken(pc) ? mTarget[idxOf(pc)] : pc + 32'd4;
   endfunction

   function automatic void modelReset();
      for (int i = 0; i < ENTRIES; i++) begin
         mValid[i]  = 0;
         mTag[i]    = '0;
         mTarget[i] = '0;
         mCnt[i]    = 1;
      end
      mBc = 0;
      mMc = 0;
   endfunction

   task automatic step(input string nm, input logic [31:0] pcF, input logic upd,
                       input logic jmp, input logic [31:0] pcE, input logic tk,
                       input logic [31:0] tgt, input logic pTk, input logic [31:0] pTgt,
                       input logic clr);
      exp_t e;
      bit   mp;
      int   i;
      pc_f = pcF; update_en_e = upd; is_jump_e = jmp; pc_e = pcE; taken_e = tk;
      target_e = tgt; pred_taken_e = pTk; pred_target_e = pTgt; clear = clr;
      mp = upd && ((tk != pTk) || (tk && pTk && (tgt != pTgt)));
      e.name = nm;
      e.pt   = modelTaken(pcF);
      e.ptg  = modelTarget(pcF);
      e.mp   = mp;
      e.rd   = !upd ? 32'd0 : (tk ? tgt : pcE + 32'd4);
      e.bc   = 32'(mBc);
      e.mc   = 32'(mMc);
      expQ.push_back(e);
      if (!rst) begin
         if (upd) mBc = (mBc + 1) % (1 << CNT_W);
         if (mp)  mMc = (mMc + 1) % (1 << CNT_W);
         i = idxOf(pcE);
         if (clr) begin
            for (int k = 0; k < ENTRIES; k++) begin
               mValid[k] = 0;
               mCnt[k]   = 1;
            end
         end else if (upd) begin
            if (modelHit(pcE)) begin
               mCnt[i] = tk ? ((mCnt[i] == 3) ? 3 : mCnt[i] + 1)
                            : ((mCnt[i] == 0) ? 0 : mCnt[i] - 1);
               if (tk) mTarget[i] = tgt;
            end else if (tk) begin
               mValid[i]  = 1;
               mTag[i]    = tagOf(pcE);
               mTarget[i] = tgt;
               mCnt[i]    = jmp ? 3 : 2;
            end
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic cmp(input string nm, input string field, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s.%s: got 0x%08h, expected 0x%08h", nm, field, act, req);
      end
   endtask

   always @(negedge clk) begin
      if (expQ.size() > 0) begin
         exp_t e;
         e = expQ.pop_front();
         cmp(e.name, "predict_taken_f", 32'(predict_taken_f), 32'(e.pt));
         cmp(e.name, "predict_target_f", predict_target_f, e.ptg);
         cmp(e.name, "mispredict_e", 32'(mispredict_e), 32'(e.mp));
         cmp(e.name, "redirect_pc_e", redirect_pc_e, e.rd);
         cmp(e.name, "branch_count", 32'(branch_count), e.bc);
         cmp(e.name, "mispredict_count", 32'(mispredict_count), e.mc);
      end
   end

   function automatic logic [31:0] randPc();
      logic [31:0] pc;
      pc = (32'($urandom_range(0, 3)) << (IDX_W + 2)) | (32'($urandom_range(0, ENTRIES - 1)) << 2)
           | 32'($urandom_range(0, 3));
      return pc + 32'h1000;
   endfunction

   initial begin
      logic [31:0] pcE, pcF, tgt;
      logic        jmp, tk, pTk, upd, clr;
      int          waited;
      rst = 1'b1; clear = 1'b0; pc_f = '0; update_en_e = 1'b0; is_jump_e = 1'b0;
      pc_e = '0; taken_e = 1'b0; target_e = '0; pred_taken_e = 1'b0; pred_target_e = '0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      step("reset", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b0;
      step("alloc_miss", 32'h100, 1, 0, 32'h100, 1, 32'h40, 0, 32'h104, 0);
      step("hit_taken", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      step("nt_first", 32'h100, 1, 0, 32'h100, 0, 0, 1, 32'h40, 0);
      step("nt_second", 32'h100, 1, 0, 32'h100, 0, 0, 0, 32'h104, 0);
      step("nt_saturate", 32'h100, 1, 0, 32'h100, 0, 0, 0, 32'h104, 0);
      step("snt_lookup", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      step("jal_alloc", 32'h200, 1, 1, 32'h200, 1, 32'h800, 0, 32'h204, 0);
      step("alias_replace", 32'h200, 1, 0, 32'h200 + 4 * ENTRIES, 1, 32'h10, 0, 32'h224, 0);
      step("wrong_target", 32'h200, 1, 0, 32'h100, 1, 32'h80, 1, 32'h40, 0);
      step("retrain", 32'h100, 1, 0, 32'h100, 1, 32'h80, 1, 32'h80, 0);
      step("pc_wrap", 32'hFFFF_FFFC, 1, 0, 32'hFFFF_FFFC, 0, 0, 0, 32'h0, 0);
      step("target_80", 32'h100, 0, 0, 0, 0, 0, 0, 0, 0);
      step("clear_upd", 32'h100, 1, 0, 32'h300, 1, 32'h900, 0, 32'h304, 1);
      step("after_clear", 32'h220, 0, 0, 0, 0, 0, 0, 0, 0);
      step("after_clear2", 32'h300, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int n = 0; n < 16; n++)
         step("wrap_loop", 32'h100, 1, 0, 32'h100, 0, 0, 0, 32'h104, 0);

      for (int n = 0; n < 400; n++) begin
         if ($urandom_range(0, 99) < 2) begin
            rst = 1'b1;
            modelReset();
            step("async_reset", randPc(), 0, 0, 0, 0, 0, 0, 0, 0);
            rst = 1'b0;
         end
         pcF = (($urandom_range(0, 19)) == 0) ? 32'hFFFF_FFFC : randPc();
         pcE = randPc();
         upd = ($urandom_range(0, 3) != 0);
         jmp = ($urandom_range(0, 4) == 0);
         tk  = jmp ? 1'b1 : 1'($urandom_range(0, 1));
         tgt = {$urandom_range(0, 7) == 0 ? 16'hFFFF : 16'h0, 16'($urandom)} & ~32'h3;
         pTk = ($urandom_range(0, 3) == 0) ? 1'($urandom_range(0, 1)) : 1'(modelTaken(pcE));
         clr = ($urandom_range(0, 39) == 0);
         step("random", pcF, upd, jmp, pcE, tk, tgt, pTk,
              ($urandom_range(0, 3) == 0) ? tgt : modelTarget(pcE), clr);
      end

      update_en_e = 1'b0;
      clear = 1'b0;
      waited = 0;
      while (expQ.size() > 0 && waited < 5) begin
         @(posedge clk);
         waited++;
      end
      if (expQ.size() > 0) begin
         fails++;
         $display("FAIL drain: got %0d pending, expected 0", expQ.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
